// File: rtl/proc_io_bridge.sv
// proc_io_bridge: host-fed input FIFO to processor din, processor dout to host-drained output FIFO, with stall.
// Optional PROC_IO_BRIDGE_STATUS_EN adds io_status (occupancies) and sticky io_err.
module proc_io_bridge #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] proc_din,
  input  logic              proc_rd_req,
  input  logic [DATA_W-1:0] proc_dout,
  input  logic              proc_wr_req,
  output logic              proc_stall,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
`ifdef PROC_IO_BRIDGE_STATUS_EN
  output logic [15:0]       io_status,
  output logic [1:0]        io_err,
`endif
  input  logic              host_out_ready
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_in [DEPTH];
  logic [DATA_W-1:0] mem_out [DEPTH];
  logic [PW-1:0] in_rd_ptr, in_wr_ptr, out_rd_ptr, out_wr_ptr;
  logic [CNT_W-1:0] in_count, out_count;
  logic in_empty, out_full, in_push, in_pop, out_push, out_pop;
  assign in_empty = in_count == '0;
  assign out_full = out_count == CNT_W'(DEPTH);
  assign host_in_ready = !sys_rst && in_count != CNT_W'(DEPTH);
  assign host_out_valid = !sys_rst && out_count != '0;
  // A stall blocks both processor sides so a reissued instruction never duplicates a transfer
  assign proc_stall = !sys_rst && ((proc_rd_req && in_empty) || (proc_wr_req && out_full));
  assign proc_din = (sys_rst || in_empty) ? '0 : mem_in[in_rd_ptr];
  assign host_out_data = host_out_valid ? mem_out[out_rd_ptr] : '0;
  assign in_push = host_in_valid && host_in_ready;
  assign in_pop = proc_rd_req && !proc_stall && !sys_rst;
  assign out_push = proc_wr_req && !proc_stall && !sys_rst;
  assign out_pop = host_out_valid && host_out_ready;
  always_ff @(posedge clk) begin
    if (in_push) mem_in[in_wr_ptr] <= host_in_data;
    if (out_push) mem_out[out_wr_ptr] <= proc_dout;
  end
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      in_rd_ptr <= '0;
      in_wr_ptr <= '0;
      in_count <= '0;
      out_rd_ptr <= '0;
      out_wr_ptr <= '0;
      out_count <= '0;
    end else begin
      in_wr_ptr <= in_wr_ptr + PW'(in_push);
      in_rd_ptr <= in_rd_ptr + PW'(in_pop);
      in_count <= in_count + CNT_W'(in_push) - CNT_W'(in_pop);
      out_wr_ptr <= out_wr_ptr + PW'(out_push);
      out_rd_ptr <= out_rd_ptr + PW'(out_pop);
      out_count <= out_count + CNT_W'(out_push) - CNT_W'(out_pop);
    end
  end
`ifdef PROC_IO_BRIDGE_STATUS_EN
  logic [1:0] err;
  always_ff @(posedge clk) begin
    if (sys_rst) err <= '0;
    else err <= err | {proc_wr_req && out_full, proc_rd_req && in_empty};
  end
  assign io_err = sys_rst ? '0 : err;
  assign io_status = sys_rst ? '0 : {8'(in_count), 8'(out_count)};
`endif
endmodule

// File: tb/tb_proc_io_bridge.sv
// tb_proc_io_bridge: directed test-plan scenarios plus random traffic against a queue-based reference model.
module tb_proc_io_bridge;
  localparam int DEPTH = 8;
  logic clk = 0;
  logic sys_rst = 1;
  logic [15:0] host_in_data = 0, proc_dout = 0;
  logic host_in_valid = 0, proc_rd_req = 0, proc_wr_req = 0, host_out_ready = 0;
  logic host_in_ready, proc_stall, host_out_valid;
  logic [15:0] proc_din, host_out_data;
`ifdef PROC_IO_BRIDGE_STATUS_EN
  logic [15:0] io_status;
  logic [1:0] io_err;
`endif
  int n_checks = 0, n_errors = 0;
  logic [15:0] in_q[$], out_q[$];
  logic [1:0] err_m = 0;
  logic st;
  logic [15:0] din, od;

  always #5 clk = ~clk;

  proc_io_bridge #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .proc_din(proc_din), .proc_rd_req(proc_rd_req), .proc_dout(proc_dout), .proc_wr_req(proc_wr_req),
    .proc_stall(proc_stall), .host_out_data(host_out_data), .host_out_valid(host_out_valid),
`ifdef PROC_IO_BRIDGE_STATUS_EN
    .io_status(io_status), .io_err(io_err),
`endif
    .host_out_ready(host_out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, check outputs against the model, then advance the model at the edge
  task automatic step(input logic rst, input logic hv, input logic [15:0] hd, input logic rd,
                      input logic wr, input logic [15:0] dw, input logic ordy,
                      output logic o_st, output logic [15:0] o_din, output logic [15:0] o_od);
    logic e_rdy, e_st, e_ov, do_in, do_rd, do_wr, do_out;
    logic [15:0] e_din, e_od;
    logic [1:0] err_n;
    sys_rst = rst; host_in_valid = hv; host_in_data = hd; proc_rd_req = rd;
    proc_wr_req = wr; proc_dout = dw; host_out_ready = ordy;
    #1;
    e_rdy = !rst && in_q.size() < DEPTH;
    e_st = !rst && ((rd && in_q.size() == 0) || (wr && out_q.size() == DEPTH));
    e_din = (rst || in_q.size() == 0) ? 16'h0 : in_q[0];
    e_ov = !rst && out_q.size() > 0;
    e_od = e_ov ? out_q[0] : 16'h0;
    chk("host_in_ready", host_in_ready, e_rdy);
    chk("proc_stall", proc_stall, e_st);
    chk("proc_din", proc_din, e_din);
    chk("host_out_valid", host_out_valid, e_ov);
    chk("host_out_data", host_out_data, e_od);
`ifdef PROC_IO_BRIDGE_STATUS_EN
    chk("io_status", io_status, rst ? 0 : (in_q.size() << 8) | out_q.size());
    chk("io_err", io_err, rst ? 2'b0 : err_m);
`endif
    o_st = proc_stall; o_din = proc_din; o_od = host_out_data;
    do_in = hv && e_rdy;
    do_rd = rd && !e_st && !rst;
    do_wr = wr && !e_st && !rst;
    do_out = e_ov && ordy;
    err_n = err_m | {wr && out_q.size() == DEPTH, rd && in_q.size() == 0};
    @(posedge clk);
    if (rst) begin
      in_q.delete(); out_q.delete(); err_m = 0;
    end else begin
      if (do_rd) void'(in_q.pop_front());
      if (do_in) in_q.push_back(hd);
      if (do_out) void'(out_q.pop_front());
      if (do_wr) out_q.push_back(dw);
      err_m = err_n;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(0, 0, 0, 0, 0, 0, ordy, st, din, od);
  endtask

  initial begin
    logic [15:0] v3[3];
    v3 = '{16'h0011, 16'h0022, 16'h0033};
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0, 0, st, din, od);
    step(1, 1, 16'h5, 1, 1, 16'h7, 1, st, din, od);
    chk("rst_stall", st, 0);
    for (int i = 0; i < 3; i++) step(0, 1, v3[i], 0, 0, 0, 0, st, din, od);
    chk("din_first", proc_din, 16'h0011);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, st, din, od);
      chk("rd3_stall", st, 0);
      chk("rd3_data", din, v3[i]);
    end
    step(0, 1, 16'h00AB, 1, 0, 0, 0, st, din, od);
    chk("empty_rd_stall", st, 1);
    step(0, 0, 0, 1, 0, 0, 0, st, din, od);
    chk("reissue_stall", st, 0);
    chk("reissue_data", din, 16'h00AB);
    for (int i = 1; i <= 9; i++) begin
      step(0, 0, 0, 0, 1, 16'(i), 0, st, din, od);
      chk("wr_fill_stall", st, i == 9);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, st, din, od);
      chk("drain_data", od, i);
    end
    step(0, 0, 0, 0, 1, 16'd9, 0, st, din, od);
    chk("wr9_stall", st, 0);
    step(0, 0, 0, 0, 0, 0, 1, st, din, od);
    chk("drain9", od, 9);
    step(0, 0, 0, 1, 1, 16'h55, 0, st, din, od);
    chk("rdwr_stall", st, 1);
    chk("rdwr_no_write", host_out_valid, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 16'h100 + 16'(i), 0, 0, 0, 0, st, din, od);
    chk("full_ready", host_in_ready, 0);
    step(0, 1, 16'hDEAD, 0, 0, 0, 0, st, din, od);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, st, din, od);
      chk("wrap_pop", din, 16'h100 + 16'(i));
    end
    for (int i = 8; i < 11; i++) step(0, 1, 16'h100 + 16'(i), 0, 0, 0, 0, st, din, od);
    for (int i = 3; i < 11; i++) begin
      step(0, 0, 0, 1, 0, 0, 0, st, din, od);
      chk("wrap_order", din, 16'h100 + 16'(i));
    end
    for (int i = 0; i < 2; i++) step(0, 1, 16'h200 + 16'(i), 0, 1, 16'h300 + 16'(i), 0, st, din, od);
    step(1, 0, 0, 0, 0, 0, 0, st, din, od);
    chk("rst_ready", host_in_ready, 0);
    chk("rst_ovalid", host_out_valid, 0);
    chk("rst_din", proc_din, 0);
    idle(0);
    chk("post_rst_ready", host_in_ready, 1);
`ifdef PROC_IO_BRIDGE_STATUS_EN
    chk("post_rst_err", io_err, 0);
`endif
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 199) == 0, $urandom_range(0, 3) < p + 1, 16'($urandom),
             $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
             $urandom_range(0, 3) >= p, st, din, od);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
